// File: rtl/line_writeback.sv
// Cache-line writeback engine: captures a 64-byte line, wins the bus arbiter,
// issues one memory-write address beat and streams the line as eight data beats.
module line_writeback #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [63:0]                 addr,
    input  logic [BUS_DATA_WIDTH*8-1:0] data,
    input  logic                        abtr_grant,
    output logic                        abtr_reqcyc,
    output logic                        bus_busy,
    output logic                        main_bus_reqcyc,
    input  logic                        main_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0]   main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]    main_bus_reqtag,
    output logic                        ready
);

    // state | meaning
    // IDLE  | no line held, all outputs low
    // ARB   | line captured, requesting the arbiter
    // ADDR  | bus owned, address beat held until memory acks
    // DATA  | streaming beat k = beat_q, one per cycle
    // DONE  | line written, ready high until the next enable
    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        DATA,
        DONE
    } state_t;

    localparam int SYSBUS_WRITE  = 1;
    localparam int SYSBUS_MEMORY = 1;
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_WR_MEM =
        BUS_TAG_WIDTH'((SYSBUS_WRITE << 12) | (SYSBUS_MEMORY << 8));

    state_t                      state_q, state_d;
    logic [63:6]                 addr_q, addr_d;
    logic [BUS_DATA_WIDTH*8-1:0] data_q, data_d;
    logic [2:0]                  beat_q, beat_d;

    // Lines are 64-byte aligned, so the low address bits are never used.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[5:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        data_d          = data_q;
        beat_d          = beat_q;
        abtr_reqcyc     = 1'b0;
        bus_busy        = 1'b0;
        main_bus_reqcyc = 1'b0;
        main_bus_req    = '0;
        main_bus_reqtag = '0;
        ready           = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                ready = (state_q == DONE);
                if (enable) begin
                    addr_d  = addr[63:6];
                    data_d  = data;
                    state_d = ARB;
                end
            end
            ARB: begin
                abtr_reqcyc = 1'b1;
                if (abtr_grant) state_d = ADDR;
            end
            ADDR: begin
                bus_busy        = 1'b1;
                main_bus_reqcyc = 1'b1;
                main_bus_req    = BUS_DATA_WIDTH'({addr_q, 6'b0});
                main_bus_reqtag = TAG_WR_MEM;
                if (main_bus_reqack) begin
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                bus_busy        = 1'b1;
                main_bus_reqcyc = 1'b1;
                main_bus_req    = data_q[int'(beat_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                main_bus_reqtag = TAG_WR_MEM;
                beat_d          = beat_q + 3'd1;
                if (beat_q == 3'd7) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_writeback.sv
// Directed bench for line_writeback: a cycle-vector table for reset and the
// basic writeback, plus hand sequences for stalls, ignored inputs, back-to-back and reset.
module tb_line_writeback;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [63:0]  addr_in;
    logic [511:0] data_in;
    logic         grant;
    logic         abtr_reqcyc;
    logic         bus_busy;
    logic         main_bus_reqcyc;
    logic         ack;
    logic [63:0]  main_bus_req;
    logic [12:0]  main_bus_reqtag;
    logic         ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    line_writeback dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .addr            (addr_in),
        .data            (data_in),
        .abtr_grant      (grant),
        .abtr_reqcyc     (abtr_reqcyc),
        .bus_busy        (bus_busy),
        .main_bus_reqcyc (main_bus_reqcyc),
        .main_bus_reqack (ack),
        .main_bus_req    (main_bus_req),
        .main_bus_reqtag (main_bus_reqtag),
        .ready           (ready)
    );

    typedef struct packed {
        logic        abtr;
        logic        busy;
        logic        cyc;
        logic        rdy;
        logic [63:0] req;
        logic [12:0] tag;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  en;
        logic  gnt;
        logic  ack;
        outs_t exp;
    } vec_t;

    function automatic outs_t o_idle();
        return '{abtr: 1'b0, busy: 1'b0, cyc: 1'b0, rdy: 1'b0, req: 64'h0, tag: 13'h0};
    endfunction

    function automatic outs_t o_arb();
        return '{abtr: 1'b1, busy: 1'b0, cyc: 1'b0, rdy: 1'b0, req: 64'h0, tag: 13'h0};
    endfunction

    function automatic outs_t o_bus(input logic [63:0] r);
        return '{abtr: 1'b0, busy: 1'b1, cyc: 1'b1, rdy: 1'b0, req: r, tag: 13'h1100};
    endfunction

    function automatic outs_t o_done();
        return '{abtr: 1'b0, busy: 1'b0, cyc: 1'b0, rdy: 1'b1, req: 64'h0, tag: 13'h0};
    endfunction

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = base + 64'(k);
        return l;
    endfunction

    task automatic chk(input string name, input outs_t e);
        outs_t a;
        a = '{abtr: abtr_reqcyc, busy: bus_busy, cyc: main_bus_reqcyc, rdy: ready,
              req: main_bus_req, tag: main_bus_reqtag};
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s t=%0t got abtr=%b busy=%b cyc=%b rdy=%b req=%h tag=%h, expected abtr=%b busy=%b cyc=%b rdy=%b req=%h tag=%h",
                      name, $time, a.abtr, a.busy, a.cyc, a.rdy, a.req, a.tag,
                      e.abtr, e.busy, e.cyc, e.rdy, e.req, e.tag);
    endtask

    // One writeback started from IDLE/DONE. g/a = grant/ack delay in cycles,
    // ign scrambles enable/addr/data/ack during DATA, rst_k >= 0 resets during beat rst_k.
    task automatic run_xfer(input string name, input int g, input int a,
                            input logic [63:0] ad, input logic [63:0] base,
                            input bit ign, input int rst_k);
        int    last;
        outs_t e;
        last    = 11 + g + a;
        addr_in = ad;
        data_in = mk_line(base);
        enable  = 1'b1;
        grant   = 1'b0;
        ack     = 1'b0;
        @(posedge clk); #1;
        enable = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c <= 1 + g)           e = o_arb();
            else if (c <= 2 + g + a)  e = o_bus({ad[63:6], 6'b0});
            else if (c <= 10 + g + a) e = o_bus(base + 64'(c - (3 + g + a)));
            else                      e = o_done();
            chk(name, e);
            if (rst_k >= 0 && c == 3 + g + a + rst_k) begin
                reset  = 1'b1;
                enable = 1'b1;
                grant  = 1'b1;
                ack    = 1'b1;
                @(posedge clk); #1;
                reset  = 1'b0;
                enable = 1'b0;
                grant  = 1'b0;
                ack    = 1'b0;
                chk("rst_mid_burst", o_idle());
                @(posedge clk); #1;
                chk("rst_stays_idle", o_idle());
                return;
            end
            if (c < last) begin
                grant = (c >= 1 + g);
                ack   = (c >= 2 + g + a);
                if (ign && c >= 3 + g + a) begin
                    enable  = 1'($urandom_range(0, 1));
                    ack     = 1'(c);
                    addr_in = {$urandom, $urandom};
                    for (int w = 0; w < 16; w++) data_in[32*w +: 32] = $urandom;
                end
                @(posedge clk); #1;
            end
        end
        enable = 1'b0;
        grant  = 1'b0;
        ack    = 1'b0;
    endtask

    vec_t vecs[15];

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        grant   = 1'b1;
        ack     = 1'b1;
        addr_in = 64'h0000_0000_8000_1234;
        data_in = mk_line(64'hA5A5_0000_0000_0000);

        vecs[0] = '{rst: 1'b1, en: 1'b1, gnt: 1'b1, ack: 1'b1, exp: o_idle()};
        vecs[1] = '{rst: 1'b1, en: 1'b1, gnt: 1'b1, ack: 1'b1, exp: o_idle()};
        vecs[2] = '{rst: 1'b0, en: 1'b0, gnt: 1'b1, ack: 1'b1, exp: o_idle()};
        vecs[3] = '{rst: 1'b0, en: 1'b1, gnt: 1'b1, ack: 1'b1, exp: o_arb()};
        vecs[4] = '{rst: 1'b0, en: 1'b0, gnt: 1'b1, ack: 1'b1,
                    exp: o_bus(64'h0000_0000_8000_1200)};
        for (int k = 0; k < 8; k++)
            vecs[5+k] = '{rst: 1'b0, en: 1'b0, gnt: 1'b1, ack: 1'b1,
                          exp: o_bus(64'hA5A5_0000_0000_0000 + 64'(k))};
        vecs[13] = '{rst: 1'b0, en: 1'b0, gnt: 1'b1, ack: 1'b1, exp: o_done()};
        vecs[14] = '{rst: 1'b0, en: 1'b0, gnt: 1'b0, ack: 1'b0, exp: o_done()};

        for (int i = 0; i < 15; i++) begin
            reset  = vecs[i].rst;
            enable = vecs[i].en;
            grant  = vecs[i].gnt;
            ack    = vecs[i].ack;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end
        enable = 1'b0;
        grant  = 1'b0;
        ack    = 1'b0;

        run_xfer("stall", 3, 2, 64'h0000_1234_5678_9ABC, 64'h5A00_0000_0000_0010, 1'b0, -1);
        run_xfer("ignored", 1, 1, 64'h0000_0000_0000_2FC0, 64'hC3C3_0000_1000_0000, 1'b1, -1);
        run_xfer("b2b", 0, 0, 64'h40, 64'h0F0F_F0F0_0000_0100, 1'b0, -1);
        run_xfer("pre_rst", 0, 0, 64'h0000_0000_0001_0000, 64'h7777_0000_0000_0000, 1'b0, 4);
        run_xfer("post_rst", 0, 0, 64'h0000_0000_0002_0080, 64'h1234_5678_0000_0000, 1'b0, -1);

        @(posedge clk); #1;
        chk("done_hold", o_done());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
